// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared states and widths for the sequential single-precision divider
package fp_div_pkg;
  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;
  localparam int BIAS = 127;
  localparam int EXP_W = 10;
  localparam int DEF_ITER = 26;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int Q_W = 26;
  localparam int R_W = 26;
endpackage

// File: rtl/fp_div_round.sv
// fp_div_round: round-to-nearest-even then pack with overflow-to-inf and flush-to-zero
module fp_div_round import fp_div_pkg::*; (
  input  logic                    i_sign,
  input  logic signed [EXP_W-1:0] i_exp,
  input  logic [MANT_W-1:0]       i_mant,
  input  logic                    i_guard,
  input  logic                    i_sticky,
  output logic [31:0]             o_res
);
  logic                    w_inc;
  logic [MANT_W:0]         w_sum;
  logic signed [EXP_W-1:0] w_exp;
  logic                    w_ovf;
  logic                    w_unf;
  // a carry out leaves the fraction bits zero, which is exactly mantissa 1.0
  always_comb begin
    w_inc = i_guard & (i_sticky | i_mant[0]);
    w_sum = {1'b0, i_mant} + (MANT_W+1)'(w_inc);
    w_exp = i_exp + $signed({{(EXP_W-1){1'b0}}, w_sum[MANT_W]});
    w_ovf = w_exp >= $signed(EXP_W'(255));
    w_unf = w_exp[EXP_W-1] | (w_exp == '0);
    o_res = w_ovf ? {i_sign, 8'hFF, 23'h0} : w_unf ? {i_sign, 31'h0} : {i_sign, w_exp[7:0], w_sum[FRAC_W-1:0]};
  end
endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: multi-cycle restoring mantissa divider producing a raw IEEE754 single quotient
module fp_div_seq import fp_div_pkg::*; #(
  parameter int ITER = DEF_ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] temp_result
);
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  state_t                  r_state, w_next;
  logic [CW-1:0]           r_cnt;
  logic                    r_sign;
  logic signed [EXP_W-1:0] r_exp;
  logic [MANT_W-1:0]       r_m2;
  logic [R_W-1:0]          r_rem;
  logic [Q_W-1:0]          r_q;
  logic [31:0]             r_res;
  logic                    w_ge;
  logic [R_W-1:0]          w_diff;
  logic                    w_hi;
  logic [MANT_W-1:0]       w_mant;
  logic                    w_guard;
  logic                    w_sticky;
  logic signed [EXP_W-1:0] w_exp;
  logic [31:0]             w_res;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = DIVIDE;
      DIVIDE:  if (r_cnt == '0) w_next = NORM;
      NORM:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  // one restoring step and the normalisation select that feeds rounding
  always_comb begin
    w_ge = r_rem >= {2'b0, r_m2};
    w_diff = w_ge ? r_rem - {2'b0, r_m2} : r_rem;
    w_hi = r_q[Q_W-1];
    w_mant = w_hi ? r_q[Q_W-1:2] : r_q[Q_W-2:1];
    w_guard = w_hi ? r_q[1] : r_q[0];
    w_sticky = (w_hi & r_q[0]) | (|r_rem);
    w_exp = w_hi ? r_exp : r_exp - $signed(EXP_W'(1));
  end
  fp_div_round u_round (
    .i_sign   (r_sign),
    .i_exp    (w_exp),
    .i_mant   (w_mant),
    .i_guard  (w_guard),
    .i_sticky (w_sticky),
    .o_res    (w_res)
  );
  // operand load, quotient shift-in and result capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_sign <= 1'b0;
      r_exp <= '0;
      r_m2 <= '0;
      r_rem <= '0;
      r_q <= '0;
      r_res <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_cnt <= CW'(ITER - 1);
        r_sign <= in1[31] ^ in2[31];
        r_exp <= EXP_W'(in1[30:23]) - EXP_W'(in2[30:23]) + EXP_W'(BIAS);
        r_m2 <= {|in2[30:23], in2[22:0]};
        r_rem <= {2'b0, |in1[30:23], in1[22:0]};
        r_q <= '0;
      end else if (r_state == DIVIDE) begin
        r_cnt <= r_cnt - 1'b1;
        r_rem <= {w_diff[R_W-2:0], 1'b0};
        r_q <= {r_q[Q_W-2:0], w_ge};
      end
      if (r_state == NORM) r_res <= w_res;
    end
  assign busy = (r_state == DIVIDE) || (r_state == NORM);
  assign done = r_state == DONE;
  assign temp_result = r_res;
endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter ITER, default 26, sets the number of quotient bits produced, one per DIVIDE cycle.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 in1  input  32  IEEE754 single dividend.
REQ-007 in2  input  32  IEEE754 single divisor.
REQ-008 busy  output  1  high while an operation is in progress (DIVIDE, NORM).
REQ-009 done  output  1  one-cycle pulse; temp_result valid.
REQ-010 temp_result  output  32  raw quotient for the downstream special-case stage; held until the next accepted start.

Function
REQ-011 SHALL use four states: IDLE, DIVIDE, NORM, DONE.
REQ-012 In IDLE with start=1, SHALL latch in1/in2 and go to DIVIDE; start outside IDLE is ignored.
REQ-013 Load actions:
- sign = in1[31]^in2[31].
- Mantissas = {hidden,frac}, with hidden = (exp!=0).
- exp = e1 - e2 + 127, held in a 10-bit signed register.
REQ-014 DIVIDE SHALL run a restoring divide for exactly ITER cycles, producing one quotient bit per cycle, MSB first; the iteration counter counts ITER-1 down to 0.
REQ-015 After DIVIDE, Q[25:0] SHALL equal floor(m1*2^25/m2).
REQ-016 NORM (1 cycle), when Q[25]=1:
- mant=Q[25:2], guard=Q[1], sticky=Q[0]|(rem!=0).
REQ-017 NORM, when Q[25]=0:
- mant=Q[24:1], guard=Q[0], sticky=(rem!=0).
- exp decremented by 1.
REQ-018 Rounding is round-to-nearest-even:
- Increment mant when guard & (sticky | mant[0]).
- On a carry out of bit 23, increment exp; mant becomes 1.0.
REQ-019 Final exp>=255 SHALL produce {sign,8'hFF,23'h0}; final exp<=0 SHALL produce {sign,31'h0}, flush-to-zero with no denormal output.
REQ-020 DONE lasts one cycle:
- done=1, temp_result updated, busy=0.
- Next state is IDLE.
- A start in the DONE cycle is ignored.
REQ-021 Latency: a start accepted in cycle 0 SHALL give done=1 in cycle ITER+2 (cycle 28 at default). Throughput is one operation per ITER+3 cycles.
REQ-022 Zero, Inf and NaN inputs need no special handling here; the result for those inputs is don't-care, but the FSM timing is unchanged.
REQ-023 A divisor mantissa of 0 SHALL NOT hang the FSM; Q is all-ones and timing is unchanged.

Reset
REQ-024 rst=1 SHALL force, asynchronously:
- state=IDLE, busy=0, done=0, temp_result=32'h0.
- Counter, Q and remainder cleared.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL begin a fresh operation.

Structure
REQ-026 Package fp_div_pkg SHALL hold:
- The state enum.
- BIAS=127, EXP_W=10, default ITER=26.
- Field-width localparams.
REQ-027 Rounding and overflow/underflow packing (REQ-018/019) SHALL be a combinational sub-module fp_div_round, instantiated once; the FSM, divider datapath and registers stay in fp_div_seq.

Verification
REQ-028 in1=0x40C00000, in2=0x40000000, start at cycle 0 -> done=1 at cycle 28, temp_result=0x40400000.
REQ-029 in1=0x3F800000, in2=0x40400000 -> temp_result=0x3EAAAAAB (the round-up path).
REQ-030 in1=0xBF800000, in2=0x40800000 -> 0xBE800000; in1=0x7F000000, in2=0x3E800000 -> 0x7F800000 (overflow).
REQ-031 start held high from cycle 0 through cycle 30 -> exactly one done, at cycle 28; the second operation is accepted at cycle 29 and its done arrives at cycle 57.
REQ-032 rst pulsed at cycle 10 of an operation -> busy=0, done stays 0 through cycle 40, temp_result=0; a later start completes normally.
REQ-033 in1=0x00800000, in2=0x7F000000 -> temp_result=0x00000000 (underflow flush).
